adc_capture_ctrl: RTL and testbench

Parametrised capture controller for the AD9283-class 8-bit ADC expansion module. It generates a programmable ADC sample clock and sequences the ADC power-down pin with a wake-up settle period. It captures samples, optionally box-car averages them by 2^N, and buffers results in a FIFO with a valid/ready output stream. It sits between the ADC pins on the expansion header and the downstream consumer (UART formatter, display or logic-analyser logic) and runs entirely in the CLK domain.

---
 rtl/adc_capture_ctrl.sv | 124 ++++++++++++
 tb/tb_adc_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: ADC clock/power sequencer with box-car averaging and an output FIFO
// Ports: CLK/RST_n (sync, active-low); enable, div, avg_log2, clr_ovf control inputs;
//        ADC_CLK, ADC_PWR, ADC_Din to the ADC; data_out/data_valid/data_ready FWFT stream;
//        fifo_level, overflow, busy status outputs.
module adc_capture_ctrl #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int WAKE_CYCLES = 64,
  parameter int AVG_MAX     = 3,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div,
  input  logic [1:0]                    avg_log2,
  input  logic                          clr_ovf,
  output logic                          ADC_CLK,
  output logic                          ADC_PWR,
  input  logic [DATA_W-1:0]             ADC_Din,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int ACC_W = DATA_W + AVG_MAX;
  localparam int CW    = AVG_MAX + 1;
  localparam int WC_W  = $clog2(WAKE_CYCLES + 1);
  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] WAKE = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] N_MAX = 2'(AVG_MAX);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_l_q, div_l_d, cnt_q, cnt_d;
  logic [1:0]        n_l_q, n_l_d;
  logic              adc_clk_q, adc_clk_d;
  logic [WC_W-1:0]   wake_q, wake_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CW-1:0]     avg_q, avg_d, avg_last;
  logic [DATA_W-1:0] res_q, res_d;
  logic              push_q, push_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              tc, run, strobe, last, pop, full, push_ok;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  assign ADC_CLK    = adc_clk_q;
  assign ADC_PWR    = state_q == OFF;
  assign busy       = state_q != OFF;
  assign data_valid = level_q != '0;
  assign data_out   = data_valid ? mem[rd_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  always_comb begin
    tc       = cnt_q == div_l_q - DIV_W'(1);
    run      = enable && state_q != OFF;
    // the sample strobe is the cycle in which ADC_CLK is about to be registered 1->0
    strobe   = run && state_q == RUN && adc_clk_q && tc;
    avg_last = (CW'(1) << n_l_q) - CW'(1);
    last     = avg_q == avg_last;
    sum      = acc_q + ACC_W'(ADC_Din);
    state_d  = !enable ? OFF :
               state_q == OFF ? WAKE :
               (state_q == WAKE && adc_clk_q && tc && wake_q == WC_W'(WAKE_CYCLES - 1)) ? RUN : state_q;
    div_l_d  = state_q == OFF ? (div == '0 ? DIV_W'(1) : div) : div_l_q;
    n_l_d    = state_q == OFF ? (avg_log2 > N_MAX ? N_MAX : avg_log2) : n_l_q;
    cnt_d    = (!run || tc) ? '0 : cnt_q + DIV_W'(1);
    adc_clk_d = run && (adc_clk_q ^ tc);
    wake_d   = (state_q == WAKE && run) ? wake_q + WC_W'(adc_clk_q && tc) : '0;
    acc_d    = !run ? '0 : strobe ? (last ? '0 : sum) : acc_q;
    avg_d    = !run ? '0 : strobe ? (last ? '0 : avg_q + CW'(1)) : avg_q;
    push_d   = strobe && last;
    res_d    = push_d ? DATA_W'(sum >> n_l_q) : res_q;
    pop      = data_valid && data_ready;
    full     = level_q == FULL;
    push_ok  = push_q && (!full || pop);
    wr_d     = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d     = pop ? rd_q + AW'(1) : rd_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    // a fresh drop wins over a simultaneous clear
    ovf_d    = (push_q && full && !pop) || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= OFF;
      div_l_q   <= DIV_W'(1);
      n_l_q     <= '0;
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
      wake_q    <= '0;
      acc_q     <= '0;
      avg_q     <= '0;
      res_q     <= '0;
      push_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_l_q   <= div_l_d;
      n_l_q     <= n_l_d;
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
      wake_q    <= wake_d;
      acc_q     <= acc_d;
      avg_q     <= avg_d;
      res_q     <= res_d;
      push_q    <= push_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST_n && push_ok) mem[wr_q] <= res_q;
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for adc_capture_ctrl
module tb_adc_capture_ctrl;
  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] div = '0;
  logic [1:0]  avg_log2 = '0;
  logic        clr_ovf = 1'b0;
  logic        ADC_CLK, ADC_PWR;
  logic [7:0]  ADC_Din = '0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow, busy;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  samp [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_e;
  adc_capture_ctrl #(
    .DATA_W(8), .DIV_W(16), .WAKE_CYCLES(4), .AVG_MAX(2), .FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .enable(enable), .div(div), .avg_log2(avg_log2),
    .clr_ovf(clr_ovf), .ADC_CLK(ADC_CLK), .ADC_PWR(ADC_PWR), .ADC_Din(ADC_Din),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic start(input logic [15:0] d, input logic [1:0] a);
    div = d;
    avg_log2 = a;
    enable = 1'b1;
  endtask
  task automatic consume();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (samp.size() == 0) begin ok = 1; break; end
      tick(1);
    end
    chk("samples_consumed", 32'(ok), 1);
  endtask
  task automatic wait_fall();
    bit ok = 0;
    logic p;
    p = ADC_CLK;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (p && !ADC_CLK) begin ok = 1; break; end
      p = ADC_CLK;
    end
    chk("adc_clk_fall", 32'(ok), 1);
  endtask
  task automatic drain();
    bit ok = 0;
    data_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      tick(1);
    end
    chk("drain_done", 32'(ok), 1);
    tick(3);
    chk("drain_valid", 32'(data_valid), 0);
    chk("drain_level", 32'(fifo_level), 0);
  endtask
  // ADC model: a new sample is launched on every ADC_CLK rise
  initial forever begin
    @(posedge ADC_CLK);
    ADC_Din = samp.size() != 0 ? samp.pop_front() : 8'h00;
  end
  initial forever begin
    @(negedge CLK);
    if (RST_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("stream", 32'(data_out), 32'(mon_e));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_pwr", 32'(ADC_PWR), 1);
    chk("rst_busy", 32'(busy), 0);
    RST_n = 1'b1;
    tick(1);
    chk("rst_clk", 32'(ADC_CLK), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    // ramp, div=2, no averaging; first 4 ADC periods are wake-up
    data_ready = 1'b1;
    for (int i = 0; i < 12; i++) samp.push_back(8'(8'h10 + i));
    for (int i = 4; i < 12; i++) exp_q.push_back(8'(8'h10 + i));
    start(16'd2, 2'd0);
    tick(1);
    chk("wake_busy", 32'(busy), 1);
    chk("wake_pwr", 32'(ADC_PWR), 0);
    chk("wake_clk0", 32'(ADC_CLK), 0);
    tick(1);
    chk("wake_clk1", 32'(ADC_CLK), 0);
    tick(1);
    chk("first_rise", 32'(ADC_CLK), 1);
    tick(14);
    chk("wake_no_data", 32'(data_valid), 0);
    consume();
    wait_fall();
    enable = 1'b0;
    tick(1);
    chk("off_pwr", 32'(ADC_PWR), 1);
    chk("off_busy", 32'(busy), 0);
    drain();
    // averaging by 4, including full-scale without wrap
    samp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h14, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_q.push_back(8'h11);
    exp_q.push_back(8'hFF);
    start(16'd2, 2'd2);
    tick(1);
    consume();
    wait_fall();
    enable = 1'b0;
    drain();
    // overflow: 20 results into a 16-deep FIFO with no consumer
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) samp.push_back(8'hEE);
    for (int i = 0; i < 20; i++) samp.push_back(8'(8'h40 + i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    start(16'd1, 2'd0);
    tick(1);
    consume();
    wait_fall();
    enable = 1'b0;
    tick(2);
    chk("ovf_level", 32'(fifo_level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(data_out), 32'h40);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    tick(3);
    chk("stall_stable", 32'(data_out), 32'h40);
    // full FIFO: push and pop in the same cycle
    samp = '{8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h60};
    exp_q.push_back(8'h60);
    start(16'd2, 2'd0);
    tick(1);
    consume();
    wait_fall();
    data_ready = 1'b1;
    enable = 1'b0;
    tick(1);
    data_ready = 1'b0;
    chk("full_pp_level", 32'(fifo_level), 16);
    chk("full_pp_ovf", 32'(overflow), 0);
    chk("full_pp_head", 32'(data_out), 32'h41);
    drain();
    // disable with 2 of 4 samples accumulated; buffered result still drains
    data_ready = 1'b0;
    samp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h22};
    exp_q.push_back(8'h0A);
    start(16'd2, 2'd2);
    tick(1);
    consume();
    wait_fall();
    for (int i = 0; i < 50 && !ADC_CLK; i++) tick(1);
    chk("mid_clk_high", 32'(ADC_CLK), 1);
    enable = 1'b0;
    tick(1);
    chk("mid_clk_low", 32'(ADC_CLK), 0);
    chk("mid_pwr", 32'(ADC_PWR), 1);
    chk("mid_busy", 32'(busy), 0);
    tick(20);
    chk("mid_no_partial", 32'(fifo_level), 1);
    drain();
    samp = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h80};
    exp_q.push_back(8'h80);
    start(16'd2, 2'd0);
    tick(1);
    consume();
    wait_fall();
    enable = 1'b0;
    drain();
    // div=0 acts as 1, avg_log2=3 clamps to 2
    samp = '{8'h99, 8'h99, 8'h99, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hFE);
    start(16'd0, 2'd3);
    tick(1);
    chk("d0_clk_a", 32'(ADC_CLK), 0);
    tick(1);
    chk("d0_clk_b", 32'(ADC_CLK), 1);
    tick(1);
    chk("d0_clk_c", 32'(ADC_CLK), 0);
    tick(1);
    chk("d0_clk_d", 32'(ADC_CLK), 1);
    consume();
    wait_fall();
    enable = 1'b0;
    drain();
    // reset in the middle of RUN with data buffered
    data_ready = 1'b0;
    samp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h33, 8'h34, 8'h35, 8'h36};
    start(16'd1, 2'd0);
    for (int i = 0; i < 200 && fifo_level == 0; i++) tick(1);
    chk("pre_rst_level", 32'(fifo_level != 0), 1);
    RST_n = 1'b0;
    tick(1);
    chk("mrst_pwr", 32'(ADC_PWR), 1);
    chk("mrst_clk", 32'(ADC_CLK), 0);
    chk("mrst_dout", 32'(data_out), 0);
    chk("mrst_valid", 32'(data_valid), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_busy", 32'(busy), 0);
    enable = 1'b0;
    RST_n = 1'b1;
    samp.delete();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
